// File: rtl/mem_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Load hits complete in zero cycles. Load misses refill a whole line from memory,
// one beat per word in ascending order. Stores always write through to memory,
// and they update the cached word only on a hit.
module mem_dcache #(
   parameter int DATA_WIDTH = 32,
   parameter int LINES      = 16,
   parameter int WORDS      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cpu_re,
   input  logic                    cpu_we,
   input  logic [DATA_WIDTH-1:0]   cpu_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   input  logic [DATA_WIDTH/8-1:0] cpu_be,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   output logic                    stall,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [DATA_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic                    mem_ack,
   input  logic                    mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_LO = 2 + OFF_W + IDX_W;
   localparam int TAG_W  = DATA_WIDTH - TAG_LO;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_REQ = 2'd1,
      REFILL = 2'd2,
      WR     = 2'd3
   } state_t;

   state_t                   state_r;
   logic [OFF_W-1:0]         cnt_r;
   logic [LINES-1:0]         valid_r;
   logic [TAG_W-1:0]         tag_mem_r  [LINES];
   logic [DATA_WIDTH-1:0]    data_mem_r [LINES*WORDS];

   logic                     mem_req_r;
   logic                     mem_we_r;
   logic [DATA_WIDTH-1:0]    mem_addr_r;
   logic [DATA_WIDTH-1:0]    mem_wdata_r;
   logic [BYTES-1:0]         mem_be_r;

   logic [OFF_W-1:0]         off_s;
   logic [IDX_W-1:0]         idx_s;
   logic [TAG_W-1:0]         tag_s;
   logic                     hit_s;
   logic                     stall_s;
   logic                     refill_we_s;
   logic                     refill_last_s;
   logic                     store_we_s;
   logic                     unused_addr_s;

   // The CPU holds its address while stalled, so the live request fields
   // remain valid for the whole transaction.
   assign off_s = cpu_addr[2 +: OFF_W];
   assign idx_s = cpu_addr[2 + OFF_W +: IDX_W];
   assign tag_s = cpu_addr[DATA_WIDTH-1:TAG_LO];
   assign unused_addr_s = ^cpu_addr[1:0];

   assign hit_s         = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
   assign refill_we_s   = (state_r == REFILL) && mem_rvalid;
   assign refill_last_s = (cnt_r == OFF_W'(WORDS - 1));
   assign store_we_s    = (state_r == WR) && mem_ack && hit_s;

   assign cpu_rdata = data_mem_r[{idx_s, off_s}];
   assign stall     = stall_s;
   assign mem_req   = mem_req_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign mem_be    = mem_be_r;

   // Pipeline stall: misses, stores and outstanding memory work freeze upstream.
   always_comb begin
      stall_s = 1'b0;
      case (state_r)
         IDLE:    stall_s = (cpu_re && !hit_s) || cpu_we;
         RD_REQ:  stall_s = 1'b1;
         REFILL:  stall_s = 1'b1;
         WR:      stall_s = !mem_ack;
         default: stall_s = 1'b1;
      endcase
   end

   // Controller FSM with registered memory-side outputs and the line valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         valid_r     <= '0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         mem_be_r    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cpu_we) begin
                  state_r     <= WR;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= 1'b1;
                  mem_addr_r  <= {cpu_addr[DATA_WIDTH-1:2], 2'b00};
                  mem_wdata_r <= cpu_wdata;
                  mem_be_r    <= cpu_be;
               end else if (cpu_re && !hit_s) begin
                  state_r    <= RD_REQ;
                  mem_req_r  <= 1'b1;
                  mem_we_r   <= 1'b0;
                  mem_addr_r <= {cpu_addr[DATA_WIDTH-1:2+OFF_W], {(2+OFF_W){1'b0}}};
               end
            end
            RD_REQ: begin
               if (mem_ack) begin
                  // The victim line is being overwritten and so it must not hit mid-refill.
                  state_r        <= REFILL;
                  cnt_r          <= '0;
                  mem_req_r      <= 1'b0;
                  valid_r[idx_s] <= 1'b0;
               end
            end
            REFILL: begin
               if (mem_rvalid) begin
                  if (refill_last_s) begin
                     state_r        <= IDLE;
                     cnt_r          <= '0;
                     valid_r[idx_s] <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + 1'b1;
                  end
               end
            end
            WR: begin
               if (mem_ack) begin
                  state_r   <= IDLE;
                  mem_req_r <= 1'b0;
                  mem_we_r  <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               mem_req_r <= 1'b0;
               mem_we_r  <= 1'b0;
            end
         endcase
      end
   end

   // Tag and data arrays: refill beats, final-beat tag load and store-hit byte merge.
   always_ff @(posedge clk) begin
      if (refill_we_s) begin
         data_mem_r[{idx_s, cnt_r}] <= mem_rdata;
         if (refill_last_s) begin
            tag_mem_r[idx_s] <= tag_s;
         end
      end else if (store_we_s) begin
         for (int b = 0; b < BYTES; b++) begin
            if (cpu_be[b]) begin
               data_mem_r[{idx_s, off_s}][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_dcache.sv
// Directed self-checking bench for mem_dcache: cold miss/refill, hit, store hit
// with byte enables, conflict eviction, reset mid-refill and mid-request, store miss.
module tb_mem_dcache;

   logic        clk;
   logic        rst_n;
   logic        cpu_re;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_be;
   logic [31:0] cpu_rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   mem_dcache #(.DATA_WIDTH(32), .LINES(16), .WORDS(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_re     (cpu_re),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_be     (cpu_be),
      .cpu_rdata  (cpu_rdata),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ack    (mem_ack),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Load miss: ack in RD_REQ cycle ackw, then WORDS consecutive beats from b0.
   task automatic refill(input logic [31:0] addr, input int ackw, input logic [31:0] b0,
                         input string tag);
      int stalls;
      stalls = 0;
      cpu_re   = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = addr;
      for (int k = 0; k < ackw + 5; k++) begin
         mem_ack    = (k == ackw);
         mem_rvalid = (k > ackw);
         mem_rdata  = b0 + 32'(k - ackw - 1);
         #1;
         if (stall) stalls++;
         if (k == 1) begin
            check({tag, "_req"},  {31'd0, mem_req}, 32'd1);
            check({tag, "_we"},   {31'd0, mem_we},  32'd0);
            check({tag, "_addr"}, mem_addr, {addr[31:4], 4'h0});
         end
         cyc();
      end
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      #1;
      check({tag, "_stall_cycles"}, 32'(stalls), 32'(1 + ackw + 4));
      check({tag, "_retry_stall"}, {31'd0, stall}, 32'd0);
   endtask

   // Store: one IDLE cycle then WR cycles 1..ackw with ack in the last one.
   task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                        input int ackw, input string tag);
      int reqs;
      reqs      = 0;
      cpu_re    = 1'b0;
      cpu_we    = 1'b1;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_be    = be;
      for (int k = 0; k <= ackw; k++) begin
         mem_ack = (k == ackw);
         #1;
         if (mem_req) reqs++;
         if (k == 0) check({tag, "_idle_stall"}, {31'd0, stall}, 32'd1);
         if (k == 1) begin
            check({tag, "_we"},    {31'd0, mem_we}, 32'd1);
            check({tag, "_addr"},  mem_addr, {addr[31:2], 2'b00});
            check({tag, "_wdata"}, mem_wdata, wdata);
            check({tag, "_be"},    {28'd0, mem_be}, {28'd0, be});
         end
         if (k == ackw) check({tag, "_ack_stall"}, {31'd0, stall}, 32'd0);
         cyc();
      end
      cpu_we  = 1'b0;
      mem_ack = 1'b0;
      #1;
      check({tag, "_req_cycles"}, 32'(reqs), 32'(ackw));
      check({tag, "_req_done"}, {31'd0, mem_req}, 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      cpu_re     = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = 32'd0;
      cpu_wdata  = 32'd0;
      cpu_be     = 4'd0;
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we",  {31'd0, mem_we},  32'd0);
      check("rst_stall",   {31'd0, stall},   32'd0);
      rst_n = 1'b1;
      cyc();

      // Cold load miss, ack after 2 cycles, beats A0..A3
      refill(32'h0000_0104, 2, 32'h0000_00A0, "cold");
      check("cold_retry_data", cpu_rdata, 32'h0000_00A1);
      cyc();

      // Hit on neighbouring word
      cpu_addr = 32'h0000_0108;
      #1;
      check("hit_stall", {31'd0, stall}, 32'd0);
      check("hit_data",  cpu_rdata, 32'h0000_00A2);
      check("hit_req",   {31'd0, mem_req}, 32'd0);
      cyc();

      // Stray ack/rvalid while idle must be ignored
      cpu_re     = 1'b0;
      mem_ack    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      #1;
      check("idle_nop_stall", {31'd0, stall}, 32'd0);
      check("idle_nop_req",   {31'd0, mem_req}, 32'd0);
      cyc();
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      cpu_re     = 1'b1;
      cpu_addr   = 32'h0000_0104;
      #1;
      check("stray_data",  cpu_rdata, 32'h0000_00A1);
      check("stray_stall", {31'd0, stall}, 32'd0);
      check("stray_req",   {31'd0, mem_req}, 32'd0);
      cyc();

      // Store hit with low two bytes enabled, ack after 3 cycles
      store(32'h0000_0104, 32'h1122_3344, 4'b0011, 3, "st_hit");
      cpu_re   = 1'b1;
      cpu_addr = 32'h0000_0104;
      #1;
      check("st_hit_load_data",  cpu_rdata, 32'h0000_3344);
      check("st_hit_load_stall", {31'd0, stall}, 32'd0);
      cyc();

      // Conflict: same index, new tag
      refill(32'h0000_1104, 1, 32'h0000_00B0, "conflict");
      check("conflict_retry_data", cpu_rdata, 32'h0000_00B1);
      cyc();
      cpu_addr = 32'h0000_0104;
      #1;
      check("evicted_miss", {31'd0, stall}, 32'd1);

      // Refill of 0x104 interrupted by reset after beat 2
      cyc();
      mem_ack = 1'b1;
      #1;
      check("part_req", {31'd0, mem_req}, 32'd1);
      cyc();
      mem_ack    = 1'b0;
      mem_rvalid = 1'b1;
      for (int b = 0; b < 3; b++) begin
         mem_rdata = 32'h0000_00C0 + 32'(b);
         #1;
         check("part_stall", {31'd0, stall}, 32'd1);
         cyc();
      end
      mem_rvalid = 1'b0;
      rst_n      = 1'b0;
      #1;
      check("part_rst_req", {31'd0, mem_req}, 32'd0);
      check("part_rst_we",  {31'd0, mem_we},  32'd0);
      cyc();
      rst_n = 1'b1;
      #1;
      check("post_rst_miss", {31'd0, stall}, 32'd1);
      refill(32'h0000_0104, 1, 32'h0000_00D0, "post_rst");
      check("post_rst_retry_data", cpu_rdata, 32'h0000_00D1);
      cyc();

      // Store miss to index 0 with a different tag: memory write only
      store(32'h0000_0200, 32'hDEAD_BEEF, 4'b1111, 1, "st_miss");
      cpu_re   = 1'b1;
      cpu_addr = 32'h0000_0104;
      #1;
      check("st_miss_keep_data",  cpu_rdata, 32'h0000_00D1);
      check("st_miss_keep_stall", {31'd0, stall}, 32'd0);
      cyc();
      cpu_addr = 32'h0000_0200;
      #1;
      check("st_miss_load_miss", {31'd0, stall}, 32'd1);
      cyc();
      check("rdreq_req",  {31'd0, mem_req}, 32'd1);
      check("rdreq_addr", mem_addr, 32'h0000_0200);

      // Reset while a read request is outstanding drops it immediately
      rst_n = 1'b0;
      #1;
      check("rdreq_rst_req", {31'd0, mem_req}, 32'd0);
      cyc();
      rst_n  = 1'b1;
      cpu_re = 1'b0;
      #1;
      check("final_stall", {31'd0, stall}, 32'd0);
      check("final_req",   {31'd0, mem_req}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
